// File: rtl/turbo_itl_ctrl.sv
// Turbo interleaver control FSM: load phase, gapped interleave/deinterleave passes, done pulse.
// Optional read-stall input is enabled by defining TURBO_ITL_CTRL_STALL_EN.
module turbo_itl_ctrl #(
  parameter int GAP_CYC = 2,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        pb_size,
  input  logic [3:0]        cfg_iter,
  input  logic              frm_start,
  input  logic              abort,
  input  logic              din_vld,
`ifdef TURBO_ITL_CTRL_STALL_EN
  input  logic              rd_stall,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              itl_start,
  output logic              itl_mode,
  output logic [4:0]        pass_idx,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              err_ovf
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    PASS,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_64   = ADDR_W'(63);
  localparam logic [ADDR_W-1:0] LAST_544  = ADDR_W'(543);
  localparam logic [ADDR_W-1:0] LAST_2080 = ADDR_W'(2079);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYC - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] last_next;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [4:0]        npass_reg;
  logic [4:0]        npass_next;
  logic [4:0]        pass_cnt_reg;
  logic [4:0]        pass_cnt_next;
  logic [4:0]        pass_idx_reg;
  logic [4:0]        pass_idx_next;
  logic [3:0]        gap_cnt_reg;
  logic [3:0]        gap_cnt_next;
  logic              itl_start_reg;
  logic              itl_start_next;
  logic              itl_mode_reg;
  logic              itl_mode_next;
  logic              rd_en_reg;
  logic              rd_en_next;
  logic              busy_reg;
  logic              busy_next;
  logic              done_reg;
  logic              done_next;
  logic              err_cfg_reg;
  logic              err_cfg_next;
  logic              err_ovf_reg;
  logic              err_ovf_next;

  logic              stall;
  logic [ADDR_W-1:0] len_last;
  logic [3:0]        iter_eff;
  logic              gap_done;

`ifdef TURBO_ITL_CTRL_STALL_EN
  // Stall masks the read strobe in the same cycle so the held address is reissued on release.
  assign stall = rd_stall & (state_reg == PASS);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    len_last = LAST_2080;
    case (pb_size)
      2'd0:    len_last = LAST_64;
      2'd1:    len_last = LAST_544;
      default: len_last = LAST_2080;
    endcase
  end

  assign iter_eff = (cfg_iter == 4'd0) ? 4'd1 : cfg_iter;
  assign gap_done = (gap_cnt_reg == GAP_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      last_reg      <= '0;
      wr_addr_reg   <= '0;
      rd_addr_reg   <= '0;
      npass_reg     <= '0;
      pass_cnt_reg  <= '0;
      pass_idx_reg  <= '0;
      gap_cnt_reg   <= '0;
      itl_start_reg <= 1'b0;
      itl_mode_reg  <= 1'b0;
      rd_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_cfg_reg   <= 1'b0;
      err_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      wr_addr_reg   <= wr_addr_next;
      rd_addr_reg   <= rd_addr_next;
      npass_reg     <= npass_next;
      pass_cnt_reg  <= pass_cnt_next;
      pass_idx_reg  <= pass_idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      itl_start_reg <= itl_start_next;
      itl_mode_reg  <= itl_mode_next;
      rd_en_reg     <= rd_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_cfg_reg   <= err_cfg_next;
      err_ovf_reg   <= err_ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    wr_addr_next   = wr_addr_reg;
    rd_addr_next   = rd_addr_reg;
    npass_next     = npass_reg;
    pass_cnt_next  = pass_cnt_reg;
    pass_idx_next  = pass_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    itl_start_next = itl_start_reg;
    itl_mode_next  = itl_mode_reg;
    rd_en_next     = rd_en_reg;
    done_next      = 1'b0;
    err_cfg_next   = 1'b0;
    err_ovf_next   = err_ovf_reg;

    // A symbol outside the load window is dropped and flagged until the next accepted frame.
    if (din_vld && (state_reg != IDLE) && (state_reg != LOAD)) begin
      err_ovf_next = 1'b1;
    end

    if (abort) begin
      state_next     = IDLE;
      rd_en_next     = 1'b0;
      itl_start_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frm_start) begin
            if (pb_size == 2'd3) begin
              err_cfg_next = 1'b1;
            end else begin
              last_next     = len_last;
              npass_next    = {iter_eff, 1'b0};
              pass_cnt_next = '0;
              wr_addr_next  = '0;
              rd_addr_next  = '0;
              err_ovf_next  = 1'b0;
              state_next    = LOAD;
            end
          end
        end
        LOAD: begin
          if (din_vld) begin
            if (wr_addr_reg == last_reg) begin
              state_next   = GAP;
              gap_cnt_next = '0;
            end else begin
              wr_addr_next = wr_addr_reg + ADDR_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            if (pass_cnt_reg < npass_reg) begin
              state_next     = PASS;
              rd_en_next     = 1'b1;
              rd_addr_next   = '0;
              itl_start_next = 1'b1;
              pass_idx_next  = pass_cnt_reg;
              itl_mode_next  = ~pass_cnt_reg[0];
            end else begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            gap_cnt_next = gap_cnt_reg + 4'd1;
          end
        end
        PASS: begin
          if (!stall) begin
            itl_start_next = 1'b0;
            if (rd_addr_reg == last_reg) begin
              state_next    = GAP;
              gap_cnt_next  = '0;
              rd_en_next    = 1'b0;
              pass_cnt_next = pass_cnt_reg + 5'd1;
            end else begin
              rd_addr_next = rd_addr_reg + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign wr_en     = (state_reg == LOAD) & din_vld & ~abort;
  assign wr_addr   = wr_addr_reg;
  assign rd_en     = rd_en_reg & ~stall;
  assign rd_addr   = rd_addr_reg;
  assign itl_start = itl_start_reg;
  assign itl_mode  = itl_mode_reg;
  assign pass_idx  = pass_idx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_cfg   = err_cfg_reg;
  assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_turbo_itl_ctrl.sv
// Directed bench for turbo_itl_ctrl: table of full frames traced against the pass schedule,
// plus hand-written sequences for config error, overflow, abort, reset and optional stall.
module tb_turbo_itl_ctrl;
  localparam int GAP = 2;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [1:0]    pb_size = 2'd0;
  logic [3:0]    cfg_iter = 4'd0;
  logic          frm_start = 1'b0;
  logic          abort = 1'b0;
  logic          din_vld = 1'b0;
`ifdef TURBO_ITL_CTRL_STALL_EN
  logic          rd_stall = 1'b0;
`endif
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          itl_start;
  logic          itl_mode;
  logic [4:0]    pass_idx;
  logic          busy;
  logic          done;
  logic          err_cfg;
  logic          err_ovf;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] pb;
    logic [3:0] iter;
    int         period;
    int         len;
    int         npass;
  } vec_t;

  vec_t vecs[4];

  turbo_itl_ctrl #(.GAP_CYC(GAP), .ADDR_W(AW)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .pb_size(pb_size),
    .cfg_iter(cfg_iter),
    .frm_start(frm_start),
    .abort(abort),
    .din_vld(din_vld),
`ifdef TURBO_ITL_CTRL_STALL_EN
    .rd_stall(rd_stall),
`endif
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .itl_start(itl_start),
    .itl_mode(itl_mode),
    .pass_idx(pass_idx),
    .busy(busy),
    .done(done),
    .err_cfg(err_cfg),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) begin
      passed++;
      $display("check %s: got %0d expected %0d ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] pb, input logic [3:0] iter);
    pb_size   = pb;
    cfg_iter  = iter;
    frm_start = 1'b1;
    @(negedge clk);
    frm_start = 1'b0;
  endtask

  // Streams len symbols with one valid every 'period' cycles; records the cycle of the last write.
  task automatic load(input int len, input int period, output int t_last, output int writes,
                      output int mism);
    writes = 0;
    mism   = 0;
    t_last = -1;
    for (int k = 0; (k < len * period + 50) && (writes < len); k++) begin
      din_vld = ((k % period) == 0);
      #1;
      if ((wr_en !== din_vld) || (wr_addr !== AW'(writes))) mism++;
      if (din_vld) begin
        if (writes == len - 1) t_last = cyc;
        writes++;
      end
      @(negedge clk);
    end
    din_vld = 1'b0;
  endtask

  task automatic wait_rd(input int pidx, input int addr, input int budget, output bit ok);
    int i;
    i = 0;
    while (!(rd_en === 1'b1 && pass_idx == 5'(pidx) && rd_addr == AW'(addr)) && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (rd_en === 1'b1 && pass_idx == 5'(pidx) && rd_addr == AW'(addr));
  endtask

  task automatic wait_done(input int budget, output int at);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    at = (done === 1'b1) ? cyc : -1;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   t, w, m, d, mism, first, rd_cycles, rel, p, off, plast;
    bit   inp, ok;
    v = vecs[vi];
    start_frame(v.pb, v.iter);
    check($sformatf("v%0d busy after start", vi), busy, 1);
    load(v.len, v.period, t, w, m);
    check($sformatf("v%0d load trace mismatches", vi), m, 0);
    check($sformatf("v%0d writes", vi), w, v.len);
    d = GAP + 1 + v.npass * (v.len + GAP);
    mism = 0;
    first = -1;
    rd_cycles = 0;
    for (int c = 1; c <= d + 1; c++) begin
      rel   = c - (GAP + 1);
      p     = (rel >= 0) ? rel / (v.len + GAP) : 0;
      off   = (rel >= 0) ? rel % (v.len + GAP) : 0;
      inp   = (rel >= 0) && (c < d) && (off < v.len);
      plast = (p < v.npass) ? p : v.npass - 1;
      ok = (rd_en === inp) && (itl_start === (inp && off == 0)) &&
           (done === (c == d)) && (busy === (c <= d)) && (wr_en === 1'b0);
      if (inp) ok = ok && (rd_addr === AW'(off));
      if (rel >= 0 && c <= d) ok = ok && (pass_idx === 5'(plast)) && (itl_mode === !plast[0]);
      if (!ok) begin
        mism++;
        if (first < 0) first = c;
      end
      if (rd_en === 1'b1) rd_cycles++;
      @(negedge clk);
    end
    check($sformatf("v%0d pass trace mismatches (first at T+%0d)", vi, first), mism, 0);
    check($sformatf("v%0d read cycles", vi), rd_cycles, v.npass * v.len);
    check($sformatf("v%0d err_ovf clear", vi), err_ovf, 0);
  endtask

  initial begin
    int  t, w, m, at, cnt_done, cnt_busy;
    bit  ok;

    vecs[0] = '{pb: 2'd0, iter: 4'd1, period: 1, len: 64,   npass: 2};
    vecs[1] = '{pb: 2'd2, iter: 4'd2, period: 2, len: 2080, npass: 4};
    vecs[2] = '{pb: 2'd1, iter: 4'd0, period: 1, len: 544,  npass: 2};
    vecs[3] = '{pb: 2'd0, iter: 4'd3, period: 3, len: 64,   npass: 6};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset flags {busy,rd_en,wr_en,done,err_cfg,err_ovf,itl_start,itl_mode}",
          {busy, rd_en, wr_en, done, err_cfg, err_ovf, itl_start, itl_mode}, 0);
    check("reset addrs {wr_addr,rd_addr,pass_idx}", {wr_addr, rd_addr, pass_idx}, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Reserved block size
    start_frame(2'd3, 4'd1);
    check("err_cfg pulse", err_cfg, 1);
    check("err_cfg busy", busy, 0);
    @(negedge clk);
    check("err_cfg single cycle", err_cfg, 0);
    check("err_cfg still idle", busy, 0);

    // Abort beats frm_start in the same cycle
    abort = 1'b1;
    start_frame(2'd0, 4'd1);
    abort = 1'b0;
    check("abort priority busy", busy, 0);

    // Reset mid-load discards the frame
    start_frame(2'd0, 4'd1);
    din_vld = 1'b1;
    repeat (10) @(negedge clk);
    din_vld = 1'b0;
    check("partial load wr_addr", wr_addr, 10);
    n_rst = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset wr_addr", wr_addr, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after reset release", busy, 0);

    // Overflow during a pass, and frm_start ignored while busy
    start_frame(2'd0, 4'd1);
    load(64, 1, t, w, m);
    check("ovf load mismatches", m, 0);
    wait_rd(0, 5, 200, ok);
    check("ovf reached rd_addr 5", ok, 1);
    din_vld = 1'b1;
    #1;
    check("ovf no write", wr_en, 0);
    @(negedge clk);
    din_vld = 1'b0;
    check("ovf flag set", err_ovf, 1);
    check("ovf pass continues {rd_en,rd_addr}", {rd_en, rd_addr}, {1'b1, 12'd6});
    wait_rd(0, 20, 200, ok);
    check("ovf reached rd_addr 20", ok, 1);
    cfg_iter  = 4'd4;
    start_frame(2'd2, 4'd4);
    check("frm_start ignored rd_addr", rd_addr, 21);
    wait_done(400, at);
    check("ovf frame done cycle", at, t + 135);
    @(negedge clk);
    check("ovf frame idle", busy, 0);
    check("ovf sticky after done", err_ovf, 1);

    // Abort in pass 1 at rd_addr 100
    start_frame(2'd1, 4'd1);
    check("err_ovf cleared by frm_start", err_ovf, 0);
    load(544, 1, t, w, m);
    check("abort load mismatches", m, 0);
    wait_rd(1, 100, 3000, ok);
    check("abort reached pass1 rd_addr 100", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort {busy,rd_en,done}", {busy, rd_en, done}, 0);
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 700; i++) begin
      if (done === 1'b1) cnt_done++;
      if (busy === 1'b1) cnt_busy++;
      @(negedge clk);
    end
    check("abort no done pulse", cnt_done, 0);
    check("abort stays idle", cnt_busy, 0);

    // Full frames from the table
    for (int i = 0; i < 4; i++) run_vec(i);

`ifdef TURBO_ITL_CTRL_STALL_EN
    start_frame(2'd0, 4'd1);
    load(64, 1, t, w, m);
    wait_rd(0, 10, 200, ok);
    check("stall reached rd_addr 10", ok, 1);
    rd_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall %0d {rd_en,rd_addr}", i), {rd_en, rd_addr}, {1'b0, 12'd10});
      @(negedge clk);
    end
    rd_stall = 1'b0;
    #1;
    check("stall release {rd_en,rd_addr}", {rd_en, rd_addr}, {1'b1, 12'd10});
    @(negedge clk);
    check("stall resume rd_addr", rd_addr, 11);
    wait_done(400, at);
    check("stall done cycle", at, t + 140);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/turbo_itl_ctrl.md
TURBO_ITL_CTRL -- requirements
Module: turbo_itl_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2: idle cycles between the load phase and pass 0, between passes, and after the final pass; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 12: width of the address buses.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pb_size, input, 2 bits: block length in symbols. 0=64, 1=544, 2=2080, 3=reserved. Sampled on frm_start.
REQ-006 SHALL have port cfg_iter, input, 4 bits: decoder iteration count, sampled on frm_start; a value of 0 is treated as 1.
REQ-007 SHALL have port frm_start, input, 1 bit: single-cycle pulse that starts a frame.
REQ-008 SHALL have port abort, input, 1 bit: synchronous pulse that terminates the frame.
REQ-009 SHALL have port din_vld, input, 1 bit: a 2-bit soft symbol is present this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: interleaver memory write strobe.
REQ-011 SHALL have port wr_addr, output, ADDR_W bits: linear write address.
REQ-012 SHALL have port rd_en, output, 1 bit: interleaver read strobe.
REQ-013 SHALL have port rd_addr, output, ADDR_W bits: linear read index; the interleaver maps it.
REQ-014 SHALL have port itl_start, output, 1 bit: pulse on the first cycle of each pass.
REQ-015 SHALL have port itl_mode, output, 1 bit: mod_int_dint for the interleaver; 1=interleave, 0=deinterleave.
REQ-016 SHALL have port pass_idx, output, 5 bits: index of the current pass.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: single-cycle pulse at frame completion.
REQ-019 SHALL have port err_cfg, output, 1 bit: pulse when frm_start arrives with pb_size=3.
REQ-020 SHALL have port err_ovf, output, 1 bit: sticky flag; din_vld arrived outside LOAD while busy.

Function
REQ-021 SHALL implement the FSM states IDLE, LOAD, GAP, PASS and DONE; all outputs except wr_en are registered.
REQ-022 SHALL, in IDLE on frm_start with pb_size<3, latch len and npass=2*max(cfg_iter,1), clear err_ovf, and enter LOAD next cycle.
REQ-023 SHALL, in IDLE on frm_start with pb_size=3, pulse err_cfg the next cycle and remain in IDLE.
REQ-024 SHALL, in LOAD, drive wr_en = din_vld (combinational); wr_addr starts at 0 and increments after each write.
REQ-025 SHALL, on the write with wr_addr=len-1, move to GAP on the next cycle; din_vld gaps of any length are tolerated.
REQ-026 SHALL hold GAP for exactly GAP_CYC cycles, then enter PASS if passes remain, else DONE.
REQ-027 SHALL, in PASS, hold rd_en=1 for len consecutive cycles with rd_addr 0..len-1 and itl_start=1 on rd_addr=0 only.
REQ-028 SHALL set itl_mode=1 on even pass_idx and itl_mode=0 on odd pass_idx; itl_mode and pass_idx change only on entry to PASS.
REQ-029 SHALL pulse done for one cycle in DONE and return to IDLE on the next cycle.
REQ-030 SHALL ignore frm_start while busy.
REQ-031 SHALL, on din_vld outside LOAD while busy, set err_ovf and discard the symbol (no write).
REQ-032 SHALL, on abort in any state, enter IDLE next cycle, deassert rd_en/wr_en and give no done pulse; abort takes priority over frm_start in the same cycle.
REQ-033 SHALL use ADDR_W-bit counters with no wrap: the terminal count len-1 is compared explicitly.

Reset
REQ-034 SHALL, while n_rst=0, put the FSM in IDLE and force wr_addr, rd_addr, pass_idx, itl_start, itl_mode, rd_en, busy, done, err_cfg and err_ovf to 0; wr_en=0 as a consequence of IDLE.
REQ-035 SHALL, on reset mid-frame, discard all frame state; a new frm_start is required.

Configuration
REQ-036 SHALL, with macro TURBO_ITL_CTRL_STALL_EN defined, add input rd_stall (1 bit); while rd_stall=1 in PASS, rd_en=0 and rd_addr, pass count and itl_start are held; the pass resumes at the same address when rd_stall=0.
REQ-037 SHALL, without TURBO_ITL_CTRL_STALL_EN, omit the rd_stall port and never pause a PASS.

Verification
REQ-038 SHALL cover: pb_size=0, cfg_iter=1, GAP_CYC=2, last write at cycle T -> pass0 T+3..T+66 with itl_mode=1, pass1 T+69..T+132 with itl_mode=0, done at T+135.
REQ-039 SHALL cover: pb_size=2, cfg_iter=2, din_vld every other cycle -> wr_addr 0..2079, four passes of 2080 cycles each, itl_mode 1,0,1,0.
REQ-040 SHALL cover: frm_start with pb_size=3 -> err_cfg one pulse, busy stays 0.
REQ-041 SHALL cover: din_vld during PASS -> err_ovf=1, no wr_en, pass continues unchanged; err_ovf clears on the next frm_start.
REQ-042 SHALL cover: abort at rd_addr=100 of pass 1 (pb_size=1) -> IDLE next cycle, rd_en=0, no done; a following frame completes normally.
REQ-043 SHALL cover, with TURBO_ITL_CTRL_STALL_EN: rd_stall high for 5 cycles at rd_addr=10 -> rd_addr held at 10, pass lasts len+5 cycles.
